alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  request n accepted this cycle.
REQ-006 req0_op / req1_op  input  3 each  ALU opcode: 000 MOV, 001 NOT, 010 ADD, 011 SUB, 100 OR, 101 AND, 110 SLT.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  WIDTH each  operands (a maps to ALU R2, b to ALU R3).
REQ-008 alu_op  output  3  opcode driven to the shared ALU.
REQ-009 alu_a, alu_b  output  WIDTH each  operands driven to the shared ALU.
REQ-010 alu_r  input  WIDTH  combinational ALU result.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_ready  input  1  consumer accepts result.
REQ-013 rsp_id  output  1  index of requester that owns the result.
REQ-014 rsp_data  output  WIDTH  registered result.
REQ-015 rsp_err  output  1  opcode was 111 (illegal).

Function
REQ-016 FSM states SHALL be IDLE, EXEC, RESP; exactly one active.
REQ-017 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready in the same cycle (combinational from state, valids, pointer), capture op/a/b/id into internal registers, go to EXEC; else stay IDLE.
REQ-018 At most one reqN_ready SHALL be high in any cycle; both SHALL be low outside IDLE.
REQ-019 Arbitration: round-robin pointer rr; if only one valid, grant it; if both valid, grant requester rr.
REQ-020 After a grant to requester n, rr SHALL become the other index (1-n).
REQ-021 EXEC: alu_op/alu_a/alu_b driven from captured registers; at clock edge rsp_data <= alu_r, rsp_id <= captured id, rsp_err <= 0; go to RESP.
REQ-022 Captured opcode 111: EXEC SHALL load rsp_data = 0, rsp_err = 1 regardless of alu_r.
REQ-023 alu_op/alu_a/alu_b SHALL hold captured register values in all states (no combinational path from reqN inputs).
REQ-024 RESP: rsp_valid = 1; rsp_data, rsp_id, rsp_err stable until rsp_ready sampled high, then go to IDLE with rsp_valid = 0 next cycle.
REQ-025 rsp_ready while not RESP SHALL be ignored.
REQ-026 Latency: request accept (cycle T) -> rsp_valid high at T+2; minimum 3 cycles between grants.
REQ-027 Requests arriving while in EXEC/RESP SHALL wait, not be dropped or reordered; requester holds valid and operands until ready.
REQ-028 SLT result SHALL be unsigned compare, 1 or 0 zero-extended to WIDTH; ADD/SUB wrap modulo 2^WIDTH (ALU behaviour, passed through unchanged).

Reset
REQ-029 rst high at a clock edge SHALL force state IDLE, rr = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_err = 0, captured op/a/b/id = 0 (hence alu_op = 000, alu_a = alu_b = 0).
REQ-030 rst during EXEC or RESP SHALL abandon the in-flight operation; no response is produced for it.
REQ-031 reqN_ready SHALL be 0 in any cycle where rst is high.

Verification
REQ-032 Single request: req0 ADD a=5 b=7 at T -> req0_ready at T, rsp_valid at T+2 with rsp_data=12, rsp_id=0, rsp_err=0.
REQ-033 Contention: both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1, each grant 3 cycles apart.
REQ-034 Backpressure: req1 SUB a=3 b=5, rsp_ready=0 for 4 cycles -> rsp_data=0xFFFFFFFE held stable, rsp_valid stays 1, no new grant until rsp_ready=1.
REQ-035 Illegal op: req0_op=111 -> rsp_err=1, rsp_data=0; next request SLT a=2 b=9 -> rsp_data=1, rsp_err=0.
REQ-036 Reset mid-op: assert rst in RESP -> next cycle rsp_valid=0, rr=0; both then valid -> requester 0 granted first.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters. The result is valid 2 cycles after accept.
// A pending response holds rsp_* stable and blocks new grants until rsp_ready is seen.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [2:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_r,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_rr;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_id;
   logic [WIDTH-1:0] r_rsp_data;
   logic             r_rsp_id;
   logic             r_rsp_err;
   logic             w_grant0;
   logic             w_grant1;
   logic             w_grant;

   // With both valid the pointer picks; a lone valid always wins.
   assign w_grant0 = (r_state == IDLE) && !rst && req0_valid && (!req1_valid || !r_rr);
   assign w_grant1 = (r_state == IDLE) && !rst && req1_valid && (!req0_valid ||  r_rr);
   assign w_grant  = w_grant0 || w_grant1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_grant) w_next = EXEC;
         EXEC:    w_next = RESP;
         RESP:    if (rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      req0_ready = w_grant0;
      req1_ready = w_grant1;
      rsp_valid  = (r_state == RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr       <= 1'b0;
         r_op       <= 3'd0;
         r_a        <= '0;
         r_b        <= '0;
         r_id       <= 1'b0;
         r_rsp_data <= '0;
         r_rsp_id   <= 1'b0;
         r_rsp_err  <= 1'b0;
      end else begin
         if (w_grant) begin
            r_op <= w_grant1 ? req1_op : req0_op;
            r_a  <= w_grant1 ? req1_a  : req0_a;
            r_b  <= w_grant1 ? req1_b  : req0_b;
            r_id <= w_grant1;
            r_rr <= !w_grant1;
         end
         if (r_state == EXEC) begin
            // Opcode 111 has no ALU meaning, so whatever alu_r shows is discarded.
            r_rsp_data <= (r_op == 3'b111) ? '0 : alu_r;
            r_rsp_err  <= (r_op == 3'b111);
            r_rsp_id   <= r_id;
         end
      end
   end

   assign alu_op   = r_op;
   assign alu_a    = r_a;
   assign alu_b    = r_b;
   assign rsp_id   = r_rsp_id;
   assign rsp_data = r_rsp_data;
   assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the shared ALU.
module tb_alu_arbiter;
   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             req0_valid = 1'b0, req1_valid = 1'b0;
   logic             req0_ready, req1_ready;
   logic [2:0]       req0_op = 3'd0, req1_op = 3'd0;
   logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [2:0]       alu_op;
   logic [WIDTH-1:0] alu_a, alu_b, alu_r;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   always_comb begin
      case (alu_op)
         3'b000:  alu_r = alu_a;
         3'b001:  alu_r = ~alu_a;
         3'b010:  alu_r = alu_a + alu_b;
         3'b011:  alu_r = alu_a - alu_b;
         3'b100:  alu_r = alu_a | alu_b;
         3'b101:  alu_r = alu_a & alu_b;
         3'b110:  alu_r = {31'd0, (alu_a < alu_b)};
         default: alu_r = 32'hDEADBEEF;
      endcase
   end

   alu_arbiter #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b1;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      step();
      step();
      @(negedge clk);
      checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL reset_req0_ready got=%b exp=0", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL reset_req1_ready got=%b exp=0", req1_ready); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (rsp_data !== 32'd0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
      checks++; if (rsp_id !== 1'b0 || rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_id_err got=%b%b exp=00", rsp_id, rsp_err); end
      checks++; if (alu_op !== 3'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin failures++; $display("FAIL reset_alu got op=%0d a=%h b=%h exp=0", alu_op, alu_a, alu_b); end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd5; req0_b = 32'd7;
      @(negedge clk);
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL single_grant got=%b%b exp=10", req0_ready, req1_ready); end
      step();
      req0_valid = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b0) begin failures++; $display("FAIL single_exec got valid=%b rdy=%b exp=0,0", rsp_valid, req0_ready); end
      checks++; if (alu_op !== 3'b010 || alu_a !== 32'd5 || alu_b !== 32'd7) begin failures++; $display("FAIL single_alu got op=%0d a=%0d b=%0d exp=2,5,7", alu_op, alu_a, alu_b); end
      step();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
      checks++; if (rsp_data !== 32'd12 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin failures++; $display("FAIL single_rsp got data=%0d id=%b err=%b exp=12,0,0", rsp_data, rsp_id, rsp_err); end
      step();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_drop got=%b exp=0", rsp_valid); end
   endtask

   task automatic test_back_to_back();
      logic       exp0, exp1, expv, eid;
      logic [31:0] edat;
      do_reset();
      req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd1;    req0_b = 32'd2;
      req1_valid = 1'b1; req1_op = 3'b100; req1_a = 32'h0F;   req1_b = 32'hF0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         exp0 = (c % 3 == 0) && ((c / 3) % 2 == 0);
         exp1 = (c % 3 == 0) && ((c / 3) % 2 == 1);
         expv = (c % 3 == 2);
         checks++; if (req0_ready !== exp0 || req1_ready !== exp1) begin failures++; $display("FAIL b2b_grant c=%0d got=%b%b exp=%b%b", c, req0_ready, req1_ready, exp0, exp1); end
         checks++; if (rsp_valid !== expv) begin failures++; $display("FAIL b2b_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, expv); end
         if (c % 3 == 2) begin
            eid  = ((c / 3) % 2 == 1);
            edat = eid ? 32'hFF : 32'd3;
            checks++; if (rsp_id !== eid || rsp_data !== edat) begin failures++; $display("FAIL b2b_rsp c=%0d got id=%b data=%h exp id=%b data=%h", c, rsp_id, rsp_data, eid, edat); end
         end
         step();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
      rsp_ready = 1'b0;
      req1_valid = 1'b1; req1_op = 3'b011; req1_a = 32'd3; req1_b = 32'd5;
      @(negedge clk);
      checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin failures++; $display("FAIL bp_grant got=%b%b exp=01", req0_ready, req1_ready); end
      step();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'h55; req0_b = 32'd0;
      @(negedge clk);
      checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL bp_exec_ready got=%b exp=0", req0_ready); end
      step();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFFFFFE || rsp_id !== 1'b1 || rsp_err !== 1'b0) begin failures++; $display("FAIL bp_hold i=%0d got v=%b data=%h id=%b err=%b exp 1,fffffffe,1,0", i, rsp_valid, rsp_data, rsp_id, rsp_err); end
         checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL bp_no_grant i=%0d got=%b exp=0", i, req0_ready); end
         step();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || req0_ready !== 1'b0) begin failures++; $display("FAIL bp_release got v=%b rdy=%b exp=1,0", rsp_valid, req0_ready); end
      step();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b1) begin failures++; $display("FAIL bp_next_grant got v=%b rdy=%b exp=0,1", rsp_valid, req0_ready); end
      step();
      req0_valid = 1'b0;
      step();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h55 || rsp_id !== 1'b0) begin failures++; $display("FAIL bp_waiter_rsp got v=%b data=%h id=%b exp=1,55,0", rsp_valid, rsp_data, rsp_id); end
   endtask

   task automatic test_illegal();
      do_reset();
      req0_valid = 1'b1; req0_op = 3'b111; req0_a = 32'd3; req0_b = 32'd4;
      @(negedge clk);
      checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL ill_grant got=%b exp=1", req0_ready); end
      step();
      req0_valid = 1'b0;
      step();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'd0) begin failures++; $display("FAIL ill_rsp got v=%b err=%b data=%h exp=1,1,0", rsp_valid, rsp_err, rsp_data); end
      step();
      req0_valid = 1'b1; req0_op = 3'b110; req0_a = 32'd2; req0_b = 32'd9;
      @(negedge clk);
      checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL slt_grant got=%b exp=1", req0_ready); end
      step();
      req0_valid = 1'b0;
      step();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'd1) begin failures++; $display("FAIL slt_rsp got v=%b err=%b data=%h exp=1,0,1", rsp_valid, rsp_err, rsp_data); end
   endtask

   task automatic test_reset_mid_op();
      do_reset();
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd1; req0_b = 32'd1;
      step();
      req0_valid = 1'b0;
      step();
      step();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_in_resp got=%b exp=1", rsp_valid); end
      rst = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1; req1_op = 3'b101; req1_a = 32'hF0; req1_b = 32'h3C;
      #1;
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b%b exp=00", req0_ready, req1_ready); end
      step();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin failures++; $display("FAIL mid_abandon got v=%b data=%h exp=0,0", rsp_valid, rsp_data); end
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL mid_rr_reset got=%b%b exp=10", req0_ready, req1_ready); end
      step();
      req0_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd2 || rsp_id !== 1'b0) begin failures++; $display("FAIL mid_rsp0 got v=%b data=%h id=%b exp=1,2,0", rsp_valid, rsp_data, rsp_id); end
      step();
      @(negedge clk);
      checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL mid_grant1 got=%b exp=1", req1_ready); end
      step();
      req1_valid = 1'b0;
      step();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h30 || rsp_id !== 1'b1) begin failures++; $display("FAIL mid_rsp1 got v=%b data=%h id=%b exp=1,30,1", rsp_valid, rsp_data, rsp_id); end
   endtask

   initial begin
      step();
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_illegal();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
